// File: rtl/free_list_pkg.sv
// Shared types and constants for the rename-stage free list of physical-register tags.
`ifndef N_ENTRY_ROB
`define N_ENTRY_ROB 32
`endif

package free_list_pkg;

  localparam int FL_N_FREE = `N_ENTRY_ROB;
  localparam int N_ARCH    = 32;
  localparam int FL_PRW    = $clog2(`N_ENTRY_ROB + 33);
  localparam int FL_PW     = $clog2(FL_N_FREE) + 1;

  typedef logic [FL_PRW-1:0] pr_tag_t;
  typedef logic [FL_PW-1:0]  fl_ptr_t;

  localparam pr_tag_t ZERO_REG = '0;

endpackage

// File: rtl/free_list.sv
// Circular free list of physical tags: 2-wide allocate at dispatch, 2-wide reclaim at
// retire, head checkpoint/restore for branch recovery.
module free_list
  import free_list_pkg::*;
#(
  parameter int N_FREE = FL_N_FREE,
  parameter int N_ARCH = free_list_pkg::N_ARCH,
  parameter int PRW    = FL_PRW,
  parameter int PW     = $clog2(N_FREE) + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          fetch_PR_0,
  input  logic          fetch_PR_1,
  input  logic          is_0_br,
  input  logic          rt_valid_0,
  input  logic          rt_valid_1,
  input  logic [PRW-1:0] Told_in_0,
  input  logic [PRW-1:0] Told_in_1,
  input  logic          recovery_br,
  input  logic [PW-1:0] recovery_head,
  output logic [PRW-1:0] freelist_0,
  output logic [PRW-1:0] freelist_1,
  output logic [PW-1:0] head_pointer,
  output logic [PW-1:0] free_count,
  output logic          busy
);

  localparam int IW = PW - 1;

  logic [PRW-1:0] buf_q [N_FREE];
  logic [PW-1:0]  head;
  logic [PW-1:0]  tail;
  logic [IW-1:0]  head_idx;
  logic [IW-1:0]  head_idx1;
  logic [IW-1:0]  tail_idx;
  logic [IW-1:0]  tail_idx1;
  logic [1:0]     npop;
  logic [1:0]     npush;

  assign head_idx  = head[IW-1:0];
  assign head_idx1 = head_idx + IW'(1);
  assign tail_idx  = tail[IW-1:0];
  assign tail_idx1 = tail_idx + IW'(1);

  assign free_count = tail - head;
  assign busy       = (free_count < PW'(2));

  assign npop  = busy ? 2'd0 : 2'({1'b0, fetch_PR_0} + {1'b0, fetch_PR_1});
  assign npush = 2'({1'b0, rt_valid_0} + {1'b0, rt_valid_1});

  // A lone slot-1 request takes the head tag, so it only skips ahead when slot 0 also pops.
  assign freelist_0 = buf_q[head_idx];
  assign freelist_1 = fetch_PR_0 ? buf_q[head_idx1] : buf_q[head_idx];

  // A slot-0 branch in a dual dispatch checkpoints between its own tag and slot 1's.
  assign head_pointer = (is_0_br && fetch_PR_0 && fetch_PR_1) ? (head + PW'(1))
                                                               : (head + PW'(npop));

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < N_FREE; i++) begin
        buf_q[i] <= PRW'(N_ARCH + i);
      end
      head <= '0;
      tail <= {1'b1, {IW{1'b0}}};
    end else begin
      if (rt_valid_0) begin
        buf_q[tail_idx] <= Told_in_0;
      end
      if (rt_valid_1) begin
        buf_q[rt_valid_0 ? tail_idx1 : tail_idx] <= Told_in_1;
      end
      tail <= tail + PW'(npush);
      // Recovery discards this cycle's allocations; retire pushes above still land.
      head <= recovery_br ? recovery_head : (head + PW'(npop));
    end
  end

  a_count_bound: assert property (@(posedge clock) disable iff (reset)
    free_count <= PW'(N_FREE));

  a_no_overflow_push: assert property (@(posedge clock) disable iff (reset)
    ({1'b0, free_count} + {{(PW-1){1'b0}}, npush}) <= (PW+1)'(N_FREE));

endmodule

// File: tb/tb_free_list.sv
// Randomized and directed bench for free_list against an unbounded-counter queue model.
module tb_free_list;
  import free_list_pkg::*;

  localparam int N   = FL_N_FREE;
  localparam int NA  = 32;
  localparam int PRW = FL_PRW;
  localparam int PW  = FL_PW;
  localparam int PMOD = 1 << PW;

  logic           clock;
  logic           reset;
  logic           fetch_PR_0, fetch_PR_1, is_0_br;
  logic           rt_valid_0, rt_valid_1;
  logic [PRW-1:0] Told_in_0, Told_in_1;
  logic           recovery_br;
  logic [PW-1:0]  recovery_head;
  logic [PRW-1:0] freelist_0, freelist_1;
  logic [PW-1:0]  head_pointer, free_count;
  logic           busy;

  free_list dut (
    .clock(clock), .reset(reset),
    .fetch_PR_0(fetch_PR_0), .fetch_PR_1(fetch_PR_1), .is_0_br(is_0_br),
    .rt_valid_0(rt_valid_0), .rt_valid_1(rt_valid_1),
    .Told_in_0(Told_in_0), .Told_in_1(Told_in_1),
    .recovery_br(recovery_br), .recovery_head(recovery_head),
    .freelist_0(freelist_0), .freelist_1(freelist_1),
    .head_pointer(head_pointer), .free_count(free_count), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: tags live in a ring, head/tail are ever-growing allocation/reclaim counts.
  int mem [N];
  int m_head;
  int m_tail;
  int cps[$];

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) mem[i] = NA + i;
    m_head = 0;
    m_tail = N;
  endtask

  task automatic idle();
    fetch_PR_0 = 0; fetch_PR_1 = 0; is_0_br = 0;
    rt_valid_0 = 0; rt_valid_1 = 0; Told_in_0 = '0; Told_in_1 = '0;
    recovery_br = 0; recovery_head = '0;
  endtask

  task automatic do_reset(input logic with_rec);
    @(negedge clock);
    idle();
    reset = 1;
    recovery_br = with_rec;
    recovery_head = PW'(17);
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    recovery_br = 0;
    #1;
    model_reset();
    chk("rst_fl0", int'(freelist_0), NA);
    chk("rst_fl1_nofetch", int'(freelist_1), NA);
    chk("rst_cnt", int'(free_count), N);
    chk("rst_busy", int'(busy), 0);
    chk("rst_hp", int'(head_pointer), 0);
    fetch_PR_0 = 1;
    #1;
    chk("rst_fl1", int'(freelist_1), NA + 1);
    fetch_PR_0 = 0;
    reset = 0;
  endtask

  task automatic cycle(input logic f0, input logic f1, input logic br,
                       input logic rv0, input logic rv1, input int t0, input int t1,
                       input logic rec, input int rech, output int np, output int hp);
    int cnt, e0, e1;
    logic eb;
    @(negedge clock);
    fetch_PR_0 = f0; fetch_PR_1 = f1; is_0_br = br;
    rt_valid_0 = rv0; rt_valid_1 = rv1;
    Told_in_0 = PRW'(t0); Told_in_1 = PRW'(t1);
    recovery_br = rec; recovery_head = PW'(rech % PMOD);
    #1;
    cnt = m_tail - m_head;
    eb  = (cnt < 2);
    e0  = mem[m_head % N];
    e1  = f0 ? mem[(m_head + 1) % N] : e0;
    np  = eb ? 0 : int'(f0) + int'(f1);
    hp  = (br && f0 && f1) ? m_head + 1 : m_head + np;
    chk("fl0", int'(freelist_0), e0);
    chk("fl1", int'(freelist_1), e1);
    chk("cnt", int'(free_count), cnt);
    chk("busy", int'(busy), int'(eb));
    chk("hp", int'(head_pointer), hp % PMOD);
    @(posedge clock);
    if (rv0) mem[m_tail % N] = t0;
    if (rv1) mem[(m_tail + int'(rv0)) % N] = t1;
    m_tail = m_tail + int'(rv0) + int'(rv1);
    m_head = rec ? rech : m_head + np;
  endtask

  task automatic peek(input logic f0);
    @(negedge clock);
    idle();
    fetch_PR_0 = f0;
    #1;
  endtask

  initial begin
    int np, hp;
    reset = 0;
    idle();

    // Reset values and dual/single dispatch.
    do_reset(0);
    cycle(1, 1, 0, 0, 0, 0, 0, 0, 0, np, hp);
    peek(0);
    chk("dual_fl0", int'(freelist_0), 34);
    chk("dual_cnt", int'(free_count), 30);
    cycle(0, 1, 0, 0, 0, 0, 0, 0, 0, np, hp);
    peek(0);
    chk("single_fl0", int'(freelist_0), 35);
    chk("single_cnt", int'(free_count), 29);

    // Drain to empty, then a stalled request.
    do_reset(0);
    for (int i = 0; i < 15; i++) cycle(1, 1, 0, 0, 0, 0, 0, 0, 0, np, hp);
    peek(0);
    chk("drain_cnt2", int'(free_count), 2);
    chk("drain_busy0", int'(busy), 0);
    cycle(1, 1, 0, 0, 0, 0, 0, 0, 0, np, hp);
    peek(0);
    chk("empty_cnt", int'(free_count), 0);
    chk("empty_busy", int'(busy), 1);
    cycle(1, 1, 0, 0, 0, 0, 0, 0, 0, np, hp);
    peek(0);
    chk("stall_cnt", int'(free_count), 0);
    chk("stall_fl0", int'(freelist_0), 32);

    // Refill from empty.
    cycle(0, 0, 0, 1, 1, 5, 7, 0, 0, np, hp);
    peek(1);
    chk("refill_cnt", int'(free_count), 2);
    chk("refill_fl0", int'(freelist_0), 5);
    chk("refill_fl1", int'(freelist_1), 7);
    chk("refill_busy", int'(busy), 0);
    fetch_PR_0 = 0;

    // Branch checkpoint and recovery.
    do_reset(0);
    cycle(1, 1, 1, 0, 0, 0, 0, 0, 0, np, hp);
    chk("br_hp", hp, 1);
    cycle(1, 1, 0, 0, 0, 0, 0, 0, 0, np, hp);
    peek(0);
    chk("br_cnt", int'(free_count), 28);
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 1, np, hp);
    peek(0);
    chk("rec_fl0", int'(freelist_0), 33);
    chk("rec_cnt", int'(free_count), 31);

    // Recovery together with dispatch and retire.
    cycle(1, 1, 0, 0, 0, 0, 0, 0, 0, np, hp);
    cycle(1, 1, 0, 0, 0, 0, 0, 0, 0, np, hp);
    cycle(1, 1, 0, 1, 0, 9, 0, 1, 1, np, hp);
    peek(0);
    chk("rec2_cnt", int'(free_count), 32);
    chk("rec2_fl0", int'(freelist_0), 33);
    chk("rec2_busy", int'(busy), 0);

    // Randomized traffic with branch checkpoints and recoveries.
    do_reset(0);
    cps.delete();
    for (int c = 0; c < 600; c++) begin
      logic f0, f1, br, rv0, rv1, rec;
      int t0, t1, rech, cnt, room;
      if (c == 300) begin
        do_reset(1);
        cps.delete();
      end
      cnt  = m_tail - m_head;
      room = N - cnt;
      f0   = ($urandom_range(0, 3) != 0);
      f1   = ($urandom_range(0, 3) != 0);
      br   = f0 && ($urandom_range(0, 3) == 0);
      rv0  = (room >= 1) && ($urandom_range(0, 2) != 0);
      rv1  = (room >= int'(rv0) + 1) && ($urandom_range(0, 2) != 0);
      t0   = (c % 37 == 0) ? 0 : int'($urandom_range(0, (1 << PRW) - 1));
      t1   = int'($urandom_range(0, (1 << PRW) - 1));
      rec  = 0;
      rech = 0;
      if (cps.size() > 0 && $urandom_range(0, 5) == 0) begin
        rech = cps[$];
        if (m_tail + int'(rv0) + int'(rv1) - rech <= N) begin
          rec = 1;
          void'(cps.pop_back());
        end
      end
      cycle(f0, f1, br, rv0, rv1, t0, t1, rec, rech, np, hp);
      if (!rec && br && np > 0) begin
        cps.push_back(hp);
        if (cps.size() > 8) void'(cps.pop_front());
      end
    end

    peek(0);
    chk("final_cnt", int'(free_count), m_tail - m_head);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
